mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ports i_if_req (1) and i_if_addr (32), inputs: fetch read request and word address.
REQ-004 SHALL have ports o_if_rdata (32) and o_if_valid (1), outputs: fetch read data and its 1-cycle valid pulse.
REQ-005 SHALL have LSU request inputs:
- i_lsu_req (1)
- i_lsu_wren (1)
- i_lsu_addr (32)
- i_lsu_wdata (32)
- i_lsu_bmask (4)
REQ-006 SHALL have ports o_lsu_rdata (32) and o_lsu_valid (1), outputs: LSU load data and its completion pulse, also pulsed for stores.
REQ-007 SHALL have memory-side outputs:
- o_mem_req (1)
- o_mem_wren (1)
- o_mem_addr (32)
- o_mem_wdata (32)
- o_mem_bmask (4)
REQ-008 SHALL have memory-side inputs i_mem_ack (1) and i_mem_rdata (32).
REQ-009 SHALL have input i_flush (1), from the taken-branch/jump select: it kills the in-flight fetch.
REQ-010 SHALL have outputs o_stall_fetch (1) and o_stall_memory (1), feeding the pipeline hazard logic.

Function
REQ-011 SHALL implement an FSM with states IDLE, IF_BUSY and LSU_BUSY, with at most one outstanding memory transaction.
REQ-012 In IDLE, when a request is present, SHALL grant it and enter the BUSY state one cycle later.
- Address, data and mask SHALL be latched at the grant edge.
- o_mem_req SHALL be registered and held high through the whole BUSY state.
REQ-013 Arbitration SHALL give LSU priority over fetch, except under the starvation guard (REQ-014).
REQ-014 Starvation guard: a 2-bit counter SHALL count consecutive LSU grants made while i_if_req is high.
- When the count reaches 3, the next grant SHALL go to fetch if i_if_req is high.
- The counter SHALL clear on any fetch grant, or on any LSU grant made while i_if_req is low.
REQ-015 In a BUSY state, memory-side outputs SHALL remain stable until the cycle i_mem_ack=1.
- The state SHALL return to IDLE at the next edge.
- The capture of i_mem_rdata into the response register SHALL happen at that same edge.
REQ-016 o_if_valid or o_lsu_valid SHALL pulse for exactly one cycle, in the cycle after ack; a new grant MAY be decided in that same cycle.
- Minimum request-to-valid latency: 2 cycles with same-cycle ack (grant edge, ack cycle, valid cycle).
REQ-017 o_mem_wren SHALL equal the latched i_lsu_wren in LSU_BUSY and SHALL be 0 in IF_BUSY.
- o_mem_bmask SHALL be 4'hF for fetch.
REQ-018 i_flush=1 while in IF_BUSY SHALL set a kill flag.
- The memory transaction SHALL still complete on ack.
- o_if_valid SHALL be suppressed for that transaction, and the kill flag SHALL clear on ack.
REQ-019 i_flush=1 in IDLE SHALL block a fetch grant in that cycle; i_flush SHALL NOT affect LSU transactions.
REQ-020 o_stall_fetch SHALL be combinational: 1 when i_if_req=1 and o_if_valid=0.
REQ-021 o_stall_memory SHALL be combinational: 1 when i_lsu_req=1 and o_lsu_valid=0.
REQ-022 A requester dropping its request while its transaction is in flight SHALL NOT abort the transaction.
REQ-023 o_if_rdata and o_lsu_rdata SHALL hold their last captured value until the next capture for that port.

Reset
REQ-024 Asserting i_reset SHALL immediately put the FSM in IDLE and clear the kill flag and the starvation counter.
REQ-025 While i_reset is asserted, all outputs SHALL be 0: o_mem_req, valids, stalls' registered terms, rdata, addr, wdata, bmask.
REQ-026 Reset mid-transaction SHALL drop the transaction.
- o_mem_req SHALL fall asynchronously.
- No valid pulse SHALL be produced for the dropped transaction.

Verification
REQ-027 Lone fetch: i_if_req=1, i_if_addr=0x100, ack one cycle after o_mem_req with rdata=0x00500093 -> o_if_valid=1 for one cycle with o_if_rdata=0x00500093, and o_stall_fetch=1 in all prior cycles.
REQ-028 Simultaneous requests: fetch 0x104 and LSU store 0x2000/0xDEADBEEF/bmask 0x3 -> LSU transaction first (o_mem_wren=1, o_mem_bmask=0x3), then fetch.
REQ-029 Starvation: LSU and fetch requests held high continuously -> grant sequence LSU, LSU, LSU, IF, repeating.
REQ-030 Flush: i_flush=1 during IF_BUSY with ack delayed 3 cycles -> o_mem_req stays high until ack, and o_if_valid stays 0.
REQ-031 Reset: i_reset pulsed in LSU_BUSY before ack -> o_mem_req=0 immediately, no o_lsu_valid, and the next request is granted from IDLE.
REQ-032 Back-to-back: fetch request held with ack always 1 -> o_if_valid pulses every 2 cycles and addresses match the requests.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between instruction fetch and LSU.
// One outstanding transaction, LSU priority with a fetch starvation guard.
module mem_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  input  logic        i_lsu_req,
  input  logic        i_lsu_wren,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [3:0]  i_lsu_bmask,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_valid,
  output logic        o_mem_req,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_flush,
  output logic        o_stall_fetch,
  output logic        o_stall_memory
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF_BUSY,
    S_LSU_BUSY
  } state_t;

  state_t      r_state;
  logic [1:0]  r_starve;
  logic        r_kill;
  logic        r_mem_req;
  logic        r_mem_wren;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_bmask;
  logic [31:0] r_if_rdata;
  logic        r_if_valid;
  logic [31:0] r_lsu_rdata;
  logic        r_lsu_valid;

  logic        w_if_elig;
  logic        w_starved;
  logic        w_grant_if;
  logic        w_grant_lsu;
  logic        w_if_kill;
  logic [1:0]  w_starve_inc;

  // A flushed fetch may not be granted; a starved fetch beats the LSU.
  assign w_if_elig    = i_if_req & ~i_flush;
  assign w_starved    = (r_starve == 2'd3);
  assign w_grant_if   = w_if_elig & (w_starved | ~i_lsu_req);
  assign w_grant_lsu  = i_lsu_req & ~w_grant_if;
  assign w_if_kill    = r_kill | i_flush;
  assign w_starve_inc = w_starved ? 2'd3 : r_starve + 2'd1;

  // Arbitration FSM with registered memory-side and response outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_starve    <= 2'd0;
      r_kill      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_wren  <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_bmask <= 4'd0;
      r_if_rdata  <= 32'd0;
      r_if_valid  <= 1'b0;
      r_lsu_rdata <= 32'd0;
      r_lsu_valid <= 1'b0;
    end else begin
      r_if_valid  <= 1'b0;
      r_lsu_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_lsu) begin
            r_state     <= S_LSU_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_wren  <= i_lsu_wren;
            r_mem_addr  <= i_lsu_addr;
            r_mem_wdata <= i_lsu_wdata;
            r_mem_bmask <= i_lsu_bmask;
            r_starve    <= i_if_req ? w_starve_inc : 2'd0;
          end else if (w_grant_if) begin
            r_state     <= S_IF_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= i_if_addr;
            r_mem_wdata <= 32'd0;
            r_mem_bmask <= 4'hF;
            r_starve    <= 2'd0;
            r_kill      <= 1'b0;
          end
        end
        S_IF_BUSY: begin
          if (i_mem_ack) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_kill     <= 1'b0;
            if (!w_if_kill) begin
              r_if_rdata <= i_mem_rdata;
              r_if_valid <= 1'b1;
            end
          end else if (i_flush) begin
            r_kill <= 1'b1;
          end
        end
        S_LSU_BUSY: begin
          if (i_mem_ack) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_lsu_rdata <= i_mem_rdata;
            r_lsu_valid <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req      = r_mem_req;
  assign o_mem_wren     = r_mem_wren;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_mem_bmask    = r_mem_bmask;
  assign o_if_rdata     = r_if_rdata;
  assign o_if_valid     = r_if_valid;
  assign o_lsu_rdata    = r_lsu_rdata;
  assign o_lsu_valid    = r_lsu_valid;
  assign o_stall_fetch  = i_if_req & ~r_if_valid;
  assign o_stall_memory = i_lsu_req & ~r_lsu_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Directed scenarios followed by a randomized phase against a memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_lsu_req;
  logic        i_lsu_wren;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_bmask;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_valid;
  logic        o_mem_req;
  logic        o_mem_wren;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        i_flush;
  logic        o_stall_fetch;
  logic        o_stall_memory;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_if_req       (i_if_req),
    .i_if_addr      (i_if_addr),
    .o_if_rdata     (o_if_rdata),
    .o_if_valid     (o_if_valid),
    .i_lsu_req      (i_lsu_req),
    .i_lsu_wren     (i_lsu_wren),
    .i_lsu_addr     (i_lsu_addr),
    .i_lsu_wdata    (i_lsu_wdata),
    .i_lsu_bmask    (i_lsu_bmask),
    .o_lsu_rdata    (o_lsu_rdata),
    .o_lsu_valid    (o_lsu_valid),
    .o_mem_req      (o_mem_req),
    .o_mem_wren     (o_mem_wren),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_bmask    (o_mem_bmask),
    .i_mem_ack      (i_mem_ack),
    .i_mem_rdata    (i_mem_rdata),
    .i_flush        (i_flush),
    .o_stall_fetch  (o_stall_fetch),
    .o_stall_memory (o_stall_memory)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
  } lexp_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] fq[$];
  lexp_t       lq[$];
  logic [31:0] rmem[logic [31:0]];
  logic [31:0] mmem[logic [31:0]];
  bit          grants[$];
  int          delay_mode = 0;
  bit          rnd = 0;
  int          b2b_if = 0;
  int          b2b_lsu = 0;
  bit          f_busy = 0;
  bit          l_busy = 0;
  bit          f_gnt = 0;
  bit          l_gnt = 0;
  bit          got_if = 0;
  bit          got_lsu = 0;
  int          n_ifv = 0;
  int          n_lsuv = 0;
  int          rsp_cnt = 0;
  bit          rsp_act = 0;
  bit          hold_unknown = 0;
  logic [31:0] last_if = 32'd0;
  bit          m_busy = 0;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [4:0]  m_ctl;
  int          streak = 0;
  bit          p_ack = 0;
  bit          p_if = 0;
  bit          p_lsu = 0;
  bit          p_flush = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] rrd(logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mrd(logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                        logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic issue_fetch(logic [31:0] a);
    i_if_req  = 1'b1;
    i_if_addr = a;
    fq.push_back(mrd(a));
    f_busy = 1;
    f_gnt  = 0;
  endtask

  task automatic issue_lsu(logic w, logic [31:0] a, logic [31:0] d,
                           logic [3:0] m);
    lexp_t e;
    i_lsu_req   = 1'b1;
    i_lsu_wren  = w;
    i_lsu_addr  = a;
    i_lsu_wdata = d;
    i_lsu_bmask = m;
    e.wr = w;
    if (w) begin
      e.data  = 32'd0;
      mmem[a] = merge(mrd(a), d, m);
    end else begin
      e.data = mrd(a);
    end
    lq.push_back(e);
    l_busy = 1;
    l_gnt  = 0;
  endtask

  task automatic rand_lsu();
    issue_lsu(1'($urandom_range(1, 0)),
              32'h2000 + 32'(4 * $urandom_range(7, 0)),
              $urandom, 4'($urandom_range(15, 0)));
  endtask

  // One cycle: memory responder, requester completions, random stimulus.
  task automatic step();
    @(posedge clk);
    #1;
    got_if  = o_if_valid;
    got_lsu = o_lsu_valid;
    i_mem_rdata = $urandom;
    if (rst) begin
      rsp_act   = 0;
      i_mem_ack = 1'b0;
    end else if (i_mem_ack) begin
      i_mem_ack = 1'b0;
      rsp_act   = 0;
    end else if (o_mem_req) begin
      if (!rsp_act) begin
        rsp_act = 1;
        rsp_cnt = (delay_mode < 0) ? $urandom_range(3, 0) : delay_mode;
      end
      if (rsp_cnt == 0) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = rrd(o_mem_addr);
        if (o_mem_wren)
          rmem[o_mem_addr] = merge(rrd(o_mem_addr), o_mem_wdata,
                                   o_mem_bmask);
      end else begin
        rsp_cnt--;
      end
    end
    if (got_if) begin
      n_ifv++;
      f_busy   = 0;
      i_if_req = 1'b0;
      if (b2b_if > 0) begin
        b2b_if--;
        issue_fetch(i_if_addr + 32'd4);
      end
    end
    if (got_lsu) begin
      n_lsuv++;
      l_busy    = 0;
      i_lsu_req = 1'b0;
      if (b2b_lsu > 0) begin
        b2b_lsu--;
        rand_lsu();
      end
    end
    if (rnd) begin
      if (f_busy && !f_gnt && o_mem_req && o_mem_addr < 32'h2000) begin
        f_gnt = 1;
        if ($urandom_range(3, 0) == 0) i_if_req = 1'b0;
      end
      if (l_busy && !l_gnt && o_mem_req && o_mem_addr >= 32'h2000) begin
        l_gnt = 1;
        if ($urandom_range(3, 0) == 0) i_lsu_req = 1'b0;
      end
      if (!f_busy && $urandom_range(2, 0) == 0)
        issue_fetch(32'h100 + 32'(4 * $urandom_range(255, 0)));
      if (!l_busy && $urandom_range(2, 0) == 0)
        rand_lsu();
    end
  endtask

  task automatic wait_if(output int n, input int bound);
    n = 0;
    do begin
      step();
      n++;
    end while (!got_if && n < bound);
    chk("if_valid_timeout", 32'(got_if), 32'd1);
  endtask

  task automatic wait_lsu(output int n, input int bound);
    n = 0;
    do begin
      step();
      n++;
    end while (!got_lsu && n < bound);
    chk("lsu_valid_timeout", 32'(got_lsu), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((f_busy || l_busy) && n < bound) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(f_busy || l_busy), 32'd0);
  endtask

  // Monitor: pops expected responses and checks arbitration and bus rules.
  always @(negedge clk) begin
    int   exp_k;
    bit   kind;
    lexp_t e;
    if (rst) begin
      chk("rst_ctl", 32'({o_mem_req, o_mem_wren, o_mem_bmask, o_if_valid,
                          o_lsu_valid}), 32'd0);
      chk("rst_addr", o_mem_addr, 32'd0);
      chk("rst_wdata", o_mem_wdata, 32'd0);
      chk("rst_if_rdata", o_if_rdata, 32'd0);
      chk("rst_lsu_rdata", o_lsu_rdata, 32'd0);
      m_busy  = 0;
      streak  = 0;
      p_ack   = 0;
      p_if    = 0;
      p_lsu   = 0;
      p_flush = 0;
      last_if = 32'd0;
    end else begin
      chk("stall_fetch", 32'(o_stall_fetch), 32'(i_if_req && !o_if_valid));
      chk("stall_mem", 32'(o_stall_memory), 32'(i_lsu_req && !o_lsu_valid));
      if (o_if_valid) begin
        if (fq.size() == 0) begin
          chk("if_valid_unexpected", 32'(o_if_valid), 32'd0);
        end else begin
          last_if = fq.pop_front();
          chk("if_rdata", o_if_rdata, last_if);
          hold_unknown = 0;
        end
      end else if (!hold_unknown) begin
        chk("if_rdata_hold", o_if_rdata, last_if);
      end
      if (o_lsu_valid) begin
        if (lq.size() == 0) begin
          chk("lsu_valid_unexpected", 32'(o_lsu_valid), 32'd0);
        end else begin
          e = lq.pop_front();
          if (!e.wr) chk("lsu_rdata", o_lsu_rdata, e.data);
        end
      end
      if (o_mem_req && !m_busy) begin
        m_busy  = 1;
        m_addr  = o_mem_addr;
        m_wdata = o_mem_wdata;
        m_ctl   = {o_mem_wren, o_mem_bmask};
        kind    = (o_mem_addr >= 32'h2000);
        if (p_lsu && p_if && !p_flush) exp_k = (streak == 3) ? 0 : 1;
        else if (p_lsu) exp_k = 1;
        else if (p_if && !p_flush) exp_k = 0;
        else exp_k = 2;
        chk("grant_kind", 32'(kind), 32'(exp_k));
        if (!kind) streak = 0;
        else if (p_if) streak = (streak == 3) ? 3 : streak + 1;
        else streak = 0;
        grants.push_back(kind);
        if (kind) begin
          chk("lsu_addr", o_mem_addr, i_lsu_addr);
          chk("lsu_ctl", 32'(m_ctl), 32'({i_lsu_wren, i_lsu_bmask}));
          if (o_mem_wren) chk("lsu_wdata", o_mem_wdata, i_lsu_wdata);
        end else begin
          chk("if_addr", o_mem_addr, i_if_addr);
          chk("if_ctl", 32'(m_ctl), 32'h0F);
        end
      end else if (m_busy) begin
        if (!o_mem_req) begin
          chk("req_drop_before_ack", 32'(p_ack), 32'd1);
          m_busy = 0;
        end else begin
          chk("req_after_ack", 32'(p_ack), 32'd0);
          chk("hold_addr", o_mem_addr, m_addr);
          chk("hold_wdata", o_mem_wdata, m_wdata);
          chk("hold_ctl", 32'({o_mem_wren, o_mem_bmask}), 32'(m_ctl));
        end
      end
      p_ack   = i_mem_ack;
      p_if    = i_if_req;
      p_lsu   = i_lsu_req;
      p_flush = i_flush;
    end
  end

  initial begin
    int n;
    int nv;
    logic [31:0] seq;
    rst         = 1'b1;
    i_if_req    = 1'b0;
    i_if_addr   = 32'd0;
    i_lsu_req   = 1'b0;
    i_lsu_wren  = 1'b0;
    i_lsu_addr  = 32'd0;
    i_lsu_wdata = 32'd0;
    i_lsu_bmask = 4'd0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'd0;
    i_flush     = 1'b0;
    rmem[32'h100] = 32'h00500093;
    mmem[32'h100] = 32'h00500093;
    repeat (3) step();
    rst = 1'b0;
    step();

    delay_mode = 1;
    issue_fetch(32'h100);
    wait_if(n, 20);
    chk("lone_latency", 32'(n), 32'd3);
    chk("lone_rdata", o_if_rdata, 32'h00500093);

    delay_mode = 0;
    grants.delete();
    issue_fetch(32'h104);
    issue_lsu(1'b1, 32'h2000, 32'hDEADBEEF, 4'h3);
    step();
    chk("simul_wren", 32'(o_mem_wren), 32'd1);
    chk("simul_bmask", 32'(o_mem_bmask), 32'h3);
    wait_idle(40);
    chk("simul_ngrants", 32'(grants.size()), 32'd2);
    if (grants.size() == 2)
      chk("simul_order", 32'({grants[0], grants[1]}), 32'b10);
    issue_lsu(1'b0, 32'h2000, 32'd0, 4'd0);
    wait_lsu(n, 20);

    b2b_if = 9;
    nv = n_ifv;
    issue_fetch(32'h200);
    n = 0;
    while (n_ifv - nv < 10 && n < 60) begin
      step();
      n++;
    end
    chk("b2b_cycles", 32'(n), 32'd20);

    issue_fetch(32'h1C0);
    i_flush = 1'b1;
    step();
    chk("flush_idle_block", 32'(o_mem_req), 32'd0);
    i_flush = 1'b0;
    wait_if(n, 20);
    chk("flush_idle_latency", 32'(n), 32'd2);

    delay_mode = 3;
    issue_fetch(32'h180);
    step();
    chk("flush_busy_req", 32'(o_mem_req), 32'd1);
    i_flush  = 1'b1;
    i_if_req = 1'b0;
    void'(fq.pop_back());
    hold_unknown = 1;
    f_busy = 0;
    nv = n_ifv;
    step();
    i_flush = 1'b0;
    n = 0;
    while (o_mem_req && n < 20) begin
      step();
      n++;
    end
    chk("flush_req_cycles", 32'(n), 32'd3);
    repeat (3) step();
    chk("flush_no_valid", 32'(n_ifv - nv), 32'd0);
    delay_mode = 0;
    issue_fetch(32'h184);
    wait_if(n, 20);

    delay_mode = 6;
    issue_lsu(1'b0, 32'h2004, 32'd0, 4'd0);
    step();
    chk("rst_busy_req", 32'(o_mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(o_mem_req), 32'd0);
    lq.delete();
    l_busy    = 0;
    i_lsu_req = 1'b0;
    nv = n_lsuv;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("rst_no_valid", 32'(n_lsuv - nv), 32'd0);
    delay_mode = 0;
    issue_lsu(1'b0, 32'h2004, 32'd0, 4'd0);
    wait_lsu(n, 20);
    chk("rst_regrant_latency", 32'(n), 32'd2);

    grants.delete();
    b2b_if  = 1;
    b2b_lsu = 5;
    issue_fetch(32'h300);
    rand_lsu();
    wait_idle(200);
    chk("starve_ngrants", 32'(grants.size()), 32'd8);
    seq = 32'd0;
    foreach (grants[i]) seq = {seq[30:0], grants[i]};
    chk("starve_seq", seq, 32'b11101110);

    rnd = 1;
    delay_mode = -1;
    repeat (800) step();
    rnd = 0;
    wait_idle(200);
    repeat (3) step();
    chk("fq_empty", 32'(fq.size()), 32'd0);
    chk("lq_empty", 32'(lq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
